ras_spec: RTL



---
 rtl/ras_spec_pkg.sv | 23 ++
 rtl/ras_spec_if.sv | 32 +++
 rtl/ras_spec_ckpt_store.sv | 40 ++++
 rtl/ras_spec.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/ras_spec_pkg.sv
// Shared defaults, operation encoding and index-width helper for the speculative RAS.
// Checkpoint hardware is built only when OPTION_RAS_CHECKPOINT_EN is defined.
package ras_spec_pkg;

    localparam int RAS_DEPTH_DEF = 8;
    localparam int RAS_WIDTH_DEF = 31;
    localparam int RAS_CKPTS_DEF = 4;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPL,
        OP_RESTORE,
        OP_CLEAR
    } ras_op_e;

    // A single checkpoint slot still needs a 1-bit id port.
    function automatic int ras_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ras_spec_if.sv
// Fetch/execute-side request and status bundle of the speculative RAS.
// The slave modport is the RAS itself.
interface ras_spec_if #(
    parameter int WIDTH = ras_spec_pkg::RAS_WIDTH_DEF,
    parameter int CKPTS = ras_spec_pkg::RAS_CKPTS_DEF,
    parameter int IW    = ras_spec_pkg::ras_idx_w(CKPTS)
) ();
    logic             s_invalidate_i;
    logic             s_push_i;
    logic [WIDTH-1:0] s_push_addr_i;
    logic             s_pop_i;
    logic             s_ckpt_i;
    logic [IW-1:0]    s_ckpt_id_i;
    logic             s_restore_i;
    logic [IW-1:0]    s_restore_id_i;
    logic [WIDTH-1:0] s_top_o;
    logic             s_empty_o;
    logic             s_full_o;
    logic [CKPTS-1:0] s_ckpt_valid_o;

    modport slave (
        input  s_invalidate_i, s_push_i, s_push_addr_i, s_pop_i,
        input  s_ckpt_i, s_ckpt_id_i, s_restore_i, s_restore_id_i,
        output s_top_o, s_empty_o, s_full_o, s_ckpt_valid_o
    );

    modport master (
        output s_invalidate_i, s_push_i, s_push_addr_i, s_pop_i,
        output s_ckpt_i, s_ckpt_id_i, s_restore_i, s_restore_id_i,
        input  s_top_o, s_empty_o, s_full_o, s_ckpt_valid_o
    );
endinterface

// File: rtl/ras_spec_ckpt_store.sv
// Checkpoint slot array: one write port, one read port, per-slot valid flags.
// Only instantiated when OPTION_RAS_CHECKPOINT_EN is defined.
module ras_spec_ckpt_store
    import ras_spec_pkg::*;
#(
    parameter int CKPTS = RAS_CKPTS_DEF,
    parameter int SW    = 8,
    parameter int IW    = ras_idx_w(CKPTS)
) (
    input  logic             s_clk_i,
    input  logic             s_reset_i,
    input  logic             i_clear,
    input  logic             i_we,
    input  logic [IW-1:0]    i_wid,
    input  logic [SW-1:0]    i_wdata,
    input  logic [IW-1:0]    i_rid,
    output logic [SW-1:0]    o_rdata,
    output logic [CKPTS-1:0] o_valid
);
    logic [SW-1:0]    r_slot [CKPTS];
    logic [CKPTS-1:0] r_valid;

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i || i_clear) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wid] <= 1'b1;
        end
    end

    // Slot payload is qualified by r_valid, so it needs no reset.
    always_ff @(posedge s_clk_i) begin
        if (i_we) begin
            r_slot[i_wid] <= i_wdata;
        end
    end

    assign o_rdata = r_slot[i_rid];
    assign o_valid = r_valid;
endmodule

// File: rtl/ras_spec.sv
// Speculative return address stack with checkpoint/repair.
// OPTION_RAS_CHECKPOINT_EN builds the slots; otherwise restore degrades to invalidate.
module ras_spec
    import ras_spec_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int WIDTH = RAS_WIDTH_DEF,
    parameter int CKPTS = RAS_CKPTS_DEF
) (
    input  logic     s_clk_i,
    input  logic     s_reset_i,
    ras_spec_if.slave bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int SW   = PW + CNTW + WIDTH;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CNTW-1:0]  r_cnt;

    ras_op_e          w_op;
    logic [PW-1:0]    w_ptr_n;
    logic [CNTW-1:0]  w_cnt_n;
    logic             w_we;
    logic [PW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_slot_vld;
    logic [PW-1:0]    w_rd_ptr;
    logic [CNTW-1:0]  w_rd_cnt;
    logic [WIDTH-1:0] w_rd_top;
    logic [CKPTS-1:0] w_ckpt_valid;

    // Restore of an empty slot falls back to a full flush.
    always_comb begin
        w_op = OP_NONE;
        if (bus.s_invalidate_i) begin
            w_op = OP_CLEAR;
        end else if (bus.s_restore_i) begin
            w_op = w_slot_vld ? OP_RESTORE : OP_CLEAR;
        end else if (bus.s_push_i && bus.s_pop_i && (r_cnt != '0)) begin
            w_op = OP_REPL;
        end else if (bus.s_push_i) begin
            w_op = OP_PUSH;
        end else if (bus.s_pop_i && (r_cnt != '0)) begin
            w_op = OP_POP;
        end
    end

    always_comb begin
        w_ptr_n = r_ptr;
        w_cnt_n = r_cnt;
        w_we    = 1'b0;
        w_waddr = r_ptr;
        w_wdata = bus.s_push_addr_i;
        case (w_op)
            OP_CLEAR: begin
                w_ptr_n = '0;
                w_cnt_n = '0;
            end
            OP_RESTORE: begin
                w_ptr_n = w_rd_ptr;
                w_cnt_n = w_rd_cnt;
                w_we    = 1'b1;
                w_waddr = w_rd_ptr;
                w_wdata = w_rd_top;
            end
            OP_REPL: begin
                w_we = 1'b1;
            end
            OP_PUSH: begin
                w_ptr_n = r_ptr + 1'b1;
                w_we    = 1'b1;
                w_waddr = r_ptr + 1'b1;
                w_cnt_n = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
            end
            OP_POP: begin
                w_ptr_n = r_ptr - 1'b1;
                w_cnt_n = r_cnt - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            r_ptr <= w_ptr_n;
            r_cnt <= w_cnt_n;
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (!s_reset_i && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

`ifdef OPTION_RAS_CHECKPOINT_EN
    logic [WIDTH-1:0] w_top_n;
    logic [SW-1:0]    w_rd_state;
    logic             w_ckpt_we;

    // Snapshot sees the same-cycle write so a pushed address is captured as top.
    assign w_top_n   = (w_we && (w_waddr == w_ptr_n)) ? w_wdata : r_mem[w_ptr_n];
    assign w_ckpt_we = bus.s_ckpt_i && (w_op != OP_CLEAR);

    ras_spec_ckpt_store #(
        .CKPTS (CKPTS),
        .SW    (SW)
    ) u_ckpt_store (
        .s_clk_i   (s_clk_i),
        .s_reset_i (s_reset_i),
        .i_clear   (w_op == OP_CLEAR),
        .i_we      (w_ckpt_we),
        .i_wid     (bus.s_ckpt_id_i),
        .i_wdata   ({w_ptr_n, w_cnt_n, w_top_n}),
        .i_rid     (bus.s_restore_id_i),
        .o_rdata   (w_rd_state),
        .o_valid   (w_ckpt_valid)
    );

    assign {w_rd_ptr, w_rd_cnt, w_rd_top} = w_rd_state;
    assign w_slot_vld = w_ckpt_valid[bus.s_restore_id_i];
`else
    logic w_unused_ckpt;

    assign w_ckpt_valid  = '0;
    assign w_slot_vld    = 1'b0;
    assign w_rd_ptr      = '0;
    assign w_rd_cnt      = '0;
    assign w_rd_top      = '0;
    assign w_unused_ckpt = ^{bus.s_ckpt_i, bus.s_ckpt_id_i, bus.s_restore_id_i};
`endif

    assign bus.s_top_o        = (r_cnt == '0) ? '0 : r_mem[r_ptr];
    assign bus.s_empty_o      = (r_cnt == '0);
    assign bus.s_full_o       = (r_cnt == CNT_MAX);
    assign bus.s_ckpt_valid_o = w_ckpt_valid;
endmodule
